// File: rtl/riscv_pkg.sv
// Shared encodings for the load/store path: funct3 size codes, LSU FSM states, legality check.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package riscv_pkg;

   // funct3 size codes as produced by the main decoder
   typedef logic [2:0] mask_t;
   localparam mask_t MASK_B  = 3'b000;
   localparam mask_t MASK_H  = 3'b001;
   localparam mask_t MASK_W  = 3'b010;
   localparam mask_t MASK_BU = 3'b100;
   localparam mask_t MASK_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } lsu_state_t;

   // Exactly one of rd/wr, a known size code, natural alignment, and no
   // unsigned sizes on stores.
   function automatic logic lsu_legal(input logic rd, input logic wr,
                                      input mask_t mask, input logic [1:0] off);
      logic ok;
      ok = rd ^ wr;
      case (mask)
         MASK_B:  ok = ok;
         MASK_BU: ok = ok & ~wr;
         MASK_H:  ok = ok & ~off[0];
         MASK_HU: ok = ok & ~off[0] & ~wr;
         MASK_W:  ok = ok & (off == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane select + sign/zero extension for loads.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
// Ports: i_mask size code, i_off addr[1:0], i_wdata LSB-aligned store data, i_rword bus read word;
//        o_be byte enables, o_wdata lane-replicated store data, o_rdata extended load data.
module lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  i_mask,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [31:0] w_shifted;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Halfwords are always 2-byte aligned when legal, so one shift by the byte
   // offset brings either size down to the LSBs.
   assign w_shifted = i_rword >> {i_off, 3'b000};
   assign w_byte    = w_shifted[7:0];
   assign w_half    = w_shifted[15:0];

   always_comb begin
      o_be    = 4'b0000;
      o_wdata = i_wdata;
      o_rdata = i_rword;
      case (i_mask)
         MASK_B, MASK_BU: begin
            o_be    = 4'b0001 << i_off;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = (i_mask == MASK_B) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
         end
         MASK_H, MASK_HU: begin
            o_be    = 4'b0011 << {i_off[1], 1'b0};
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = (i_mask == MASK_H) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
         end
         MASK_W: begin
            o_be    = 4'b1111;
         end
         default: begin
            o_be    = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one memory op, checks legality, runs one byte-enabled bus transaction.
// Latency: illegal op done 1 cycle after accept; legal op done 1 cycle after gnt (store) or rvalid (load).
// Backpressure: req_ready only in IDLE; stall holds the core while REQ/WAIT; TIMEOUT cycles max on the bus.
// Ports: clk_i/rst_i; req_valid_i, mem_rd_i, mem_wr_i, mask_i, addr_i, wdata_i from execute;
//        req_ready, stall, done, err, rdata to the core; bus_* request side and bus_gnt_i/rvalid_i/rdata_i.
module lsu_ctrl
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = 256
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic        mem_rd_i,
   input  logic        mem_wr_i,
   input  logic [2:0]  mask_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        req_ready,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   lsu_state_t    r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_addr, r_wdata, r_rdata;
   logic [2:0]    r_mask;
   logic          r_we, r_err;

   logic          w_accept, w_legal, w_expired;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata, w_ext;

   assign w_accept  = req_valid_i && (r_state == S_IDLE);
   assign w_legal   = lsu_legal(mem_rd_i, mem_wr_i, mask_i, addr_i[1:0]);
   // >= rather than == so a load granted on the last REQ cycle still gets
   // exactly one WAIT cycle before it is aborted.
   assign w_expired = (r_cnt >= CNT_LAST);

   lsu_align u_align (
      .i_mask  (r_mask),
      .i_off   (r_addr[1:0]),
      .i_wdata (r_wdata),
      .i_rword (bus_rdata_i),
      .o_be    (w_be),
      .o_wdata (w_wdata),
      .o_rdata (w_ext)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = w_legal ? S_REQ : S_RESP;
         S_REQ: begin
            if (bus_gnt_i)      w_next = r_we ? S_RESP : S_WAIT;
            else if (w_expired) w_next = S_RESP;
         end
         S_WAIT: begin
            // rvalid is only looked at here, so one coincident with gnt is ignored
            if (bus_rvalid_i || w_expired) w_next = S_RESP;
         end
         S_RESP: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_mask  <= '0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_err <= !w_legal;
                  if (w_legal) begin
                     r_addr  <= addr_i;
                     r_wdata <= wdata_i;
                     r_mask  <= mask_i;
                     r_we    <= mem_wr_i;
                     r_cnt   <= '0;
                  end
               end
            end
            S_REQ: begin
               if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
               if (!bus_gnt_i && w_expired) r_err <= 1'b1;
            end
            S_WAIT: begin
               if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
               if (bus_rvalid_i)   r_rdata <= w_ext;
               else if (w_expired) r_err   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign stall     = (r_state == S_REQ) || (r_state == S_WAIT) || (w_accept && w_legal);
   assign done      = (r_state == S_RESP);
   assign err       = (r_state == S_RESP) && r_err;
   assign rdata     = r_rdata;

   // Bus fields are forced to zero outside REQ so the bus sees clean idle values.
   assign bus_req   = (r_state == S_REQ);
   assign bus_we    = bus_req && r_we;
   assign bus_addr  = bus_req ? {r_addr[31:2], 2'b00} : 32'd0;
   assign bus_be    = bus_req ? w_be : 4'b0000;
   assign bus_wdata = bus_req ? w_wdata : 32'd0;

endmodule
